// File: rtl/valve_seq_pkg.sv
// Shared types and defaults for the valve zone sequencer.
package valve_seq_pkg;

  localparam int unsigned NumZonesDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StOpen,
    StDead,
    StDone
  } state_e;

endpackage

// File: rtl/valve_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest request bit plus a valid flag.
module valve_prio_enc
  import valve_seq_pkg::*;
#(
  parameter int unsigned NUM_ZONES = NumZonesDefault,
  localparam int unsigned ZONE_W = $clog2(NUM_ZONES)
) (
  input  logic [NUM_ZONES-1:0] req_i,
  output logic [ZONE_W-1:0]    idx_o,
  output logic                 valid_o
);

  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    // Walk from the top down so the lowest set bit is the last one written.
    for (int i = int'(NUM_ZONES) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = ZONE_W'(i);
      end
    end
  end

endmodule

// File: rtl/valve_zone_sequencer.sv
// Watering-cycle sequencer: opens captured zones one at a time with break-before-make dead time.
// Optional manual valve override in IDLE when VALVE_SEQ_MANUAL_EN is defined.
module valve_zone_sequencer
  import valve_seq_pkg::*;
#(
  parameter int unsigned NUM_ZONES   = NumZonesDefault,
  parameter int unsigned TIME_W      = 16,
  parameter int unsigned DEAD_CYCLES = 4,
  localparam int unsigned ZONE_W = $clog2(NUM_ZONES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic [NUM_ZONES-1:0] zone_mask_i,
  input  logic [TIME_W-1:0]    duration_i,
  input  logic                 abort_i,
  output logic [NUM_ZONES-1:0] valve_o,
  output logic [ZONE_W-1:0]    cur_zone_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 aborted_o
`ifdef VALVE_SEQ_MANUAL_EN
  ,
  input  logic                 manual_req_i,
  input  logic [ZONE_W-1:0]    manual_zone_i
`endif
);

  state_e               state_q, state_d;
  logic [NUM_ZONES-1:0] pending_q, pending_d;
  logic [TIME_W-1:0]    dur_q, dur_d;
  logic [TIME_W-1:0]    cnt_q, cnt_d;
  logic [ZONE_W-1:0]    cur_zone_q, cur_zone_d;
  logic [NUM_ZONES-1:0] valve_q, valve_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;

  logic [ZONE_W-1:0]    scan_idx;
  logic                 scan_valid;

  valve_prio_enc #(
    .NUM_ZONES(NUM_ZONES)
  ) u_prio_enc (
    .req_i  (pending_q),
    .idx_o  (scan_idx),
    .valid_o(scan_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      dur_q      <= '0;
      cnt_q      <= '0;
      cur_zone_q <= '0;
      valve_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      dur_q      <= dur_d;
      cnt_q      <= cnt_d;
      cur_zone_q <= cur_zone_d;
      valve_q    <= valve_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    dur_d      = dur_q;
    cnt_d      = cnt_q;
    cur_zone_d = cur_zone_q;
    if (abort_i) begin
      state_d   = StIdle;
      pending_d = '0;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i && en_i && (zone_mask_i != '0)) begin
            pending_d = zone_mask_i;
            dur_d     = (duration_i == '0) ? TIME_W'(1) : duration_i;
            state_d   = StScan;
          end
        end
        StScan: begin
          if (en_i) begin
            if (scan_valid) begin
              cur_zone_d = scan_idx;
              pending_d  = pending_q & ~(NUM_ZONES'(1) << scan_idx);
              cnt_d      = dur_q;
              state_d    = StOpen;
            end else begin
              state_d = StDone;
            end
          end
        end
        StOpen: begin
          if (en_i) begin
            if (cnt_q <= TIME_W'(1)) begin
              if ((pending_q != '0) && (DEAD_CYCLES > 0)) begin
                state_d = StDead;
                cnt_d   = TIME_W'(DEAD_CYCLES);
              end else begin
                state_d = (pending_q != '0) ? StScan : StDone;
                cnt_d   = '0;
              end
            end else begin
              cnt_d = cnt_q - TIME_W'(1);
            end
          end
        end
        StDead: begin
          if (en_i) begin
            if (cnt_q <= TIME_W'(1)) begin
              state_d = StScan;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - TIME_W'(1);
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Valve and busy lag the state by one edge, so busy also covers the final open cycle.
  always_comb begin
    valve_d   = '0;
    done_d    = 1'b0;
    aborted_d = abort_i;
    busy_d    = (state_d inside {StScan, StOpen, StDead}) ||
                ((state_q == StOpen) && en_i && !abort_i);
    if (!abort_i) begin
      if ((state_q == StOpen) && en_i) begin
        valve_d = NUM_ZONES'(1) << cur_zone_q;
      end
      done_d = (state_q == StDone) ||
               ((state_q == StIdle) && start_i && en_i && (zone_mask_i == '0));
`ifdef VALVE_SEQ_MANUAL_EN
      if ((state_q == StIdle) && !start_i && manual_req_i &&
          (32'(manual_zone_i) < NUM_ZONES)) begin
        valve_d = NUM_ZONES'(1) << manual_zone_i;
      end
`endif
    end
  end

  assign valve_o    = valve_q;
  assign cur_zone_o = cur_zone_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign aborted_o  = aborted_q;

endmodule

// File: tb/tb_valve_zone_sequencer.sv
// Bench for valve_zone_sequencer: expected per-cycle traces are built from zone lists and timing rules.
module tb_valve_zone_sequencer;

  localparam int unsigned N      = 8;
  localparam int unsigned TW     = 16;
  localparam int unsigned DEAD   = 4;
  localparam int unsigned ZW     = $clog2(N);

  typedef struct {
    logic [N-1:0] valve;
    logic         busy;
    logic         done;
    int           zone;
  } ent_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          en_i;
  logic          start_i;
  logic [N-1:0]  zone_mask_i;
  logic [TW-1:0] duration_i;
  logic          abort_i;
  logic [N-1:0]  valve_o;
  logic [ZW-1:0] cur_zone_o;
  logic          busy_o;
  logic          done_o;
  logic          aborted_o;

  int   vectors     = 0;
  int   miscompares = 0;
  int   model_zone  = 0;
  ent_t exp_q[$];

  valve_zone_sequencer #(
    .NUM_ZONES  (N),
    .TIME_W     (TW),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .start_i    (start_i),
    .zone_mask_i(zone_mask_i),
    .duration_i (duration_i),
    .abort_i    (abort_i),
    .valve_o    (valve_o),
    .cur_zone_o (cur_zone_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .aborted_o  (aborted_o)
`ifdef VALVE_SEQ_MANUAL_EN
    ,
    .manual_req_i (1'b0),
    .manual_zone_i('0)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_all(input string tag, input ent_t e);
    chk({tag, ".valve"}, 32'(valve_o), 32'(e.valve));
    chk({tag, ".busy"}, 32'(busy_o), 32'(e.busy));
    chk({tag, ".done"}, 32'(done_o), 32'(e.done));
    chk({tag, ".aborted"}, 32'(aborted_o), 32'd0);
    chk({tag, ".cur_zone"}, 32'(cur_zone_o), 32'(e.zone));
    chk({tag, ".onehot"}, 32'($countones(valve_o) <= 1), 32'd1);
  endtask

  // Cycle-by-cycle expectation after the start edge: leading gap, open window per zone,
  // dead+scan gap between zones, then the done pulse.
  task automatic build(input logic [N-1:0] mask, input int d, input int prev_zone);
    int   dd;
    int   last;
    int   gap;
    bit   first;
    ent_t e;
    exp_q.delete();
    dd    = (d == 0) ? 1 : d;
    last  = prev_zone;
    first = 1'b1;
    for (int z = 0; z < int'(N); z++) begin
      if (mask[z]) begin
        gap = first ? 2 : int'(DEAD) + 1;
        for (int g = 0; g < gap; g++) begin
          e = '{valve: '0, busy: 1'b1, done: 1'b0, zone: (g == gap - 1) ? z : last};
          exp_q.push_back(e);
        end
        for (int c = 0; c < dd; c++) begin
          e = '{valve: N'(1) << z, busy: 1'b1, done: 1'b0, zone: z};
          exp_q.push_back(e);
        end
        last  = z;
        first = 1'b0;
      end
    end
    e = '{valve: '0, busy: 1'b0, done: 1'b1, zone: last};
    exp_q.push_back(e);
    e = '{valve: '0, busy: 1'b0, done: 1'b0, zone: last};
    exp_q.push_back(e);
  endtask

  task automatic play(input logic [N-1:0] mask, input int d, input int pause_at,
                      input int pause_len, input int abort_at);
    ent_t e;
    build(mask, d, model_zone);
    zone_mask_i = mask;
    duration_i  = TW'(d);
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    for (int j = 0; j < exp_q.size(); j++) begin
      chk_all("run", exp_q[j]);
      if (j == abort_at) begin
        abort_i     = 1'b1;
        start_i     = 1'b1;
        zone_mask_i = 8'hff;
        step();
        abort_i = 1'b0;
        start_i = 1'b0;
        chk("abort.valve", 32'(valve_o), 32'd0);
        chk("abort.busy", 32'(busy_o), 32'd0);
        chk("abort.done", 32'(done_o), 32'd0);
        chk("abort.pulse", 32'(aborted_o), 32'd1);
        step();
        chk("abort.pulse_end", 32'(aborted_o), 32'd0);
        chk("abort.idle_busy", 32'(busy_o), 32'd0);
        chk("abort.idle_valve", 32'(valve_o), 32'd0);
        model_zone = exp_q[j].zone;
        return;
      end
      if (j == pause_at) begin
        en_i = 1'b0;
        for (int p = 0; p < pause_len; p++) begin
          step();
          e = '{valve: '0, busy: 1'b1, done: 1'b0, zone: exp_q[j].zone};
          chk_all("pause", e);
        end
        en_i = 1'b1;
      end
      zone_mask_i = N'($urandom);
      duration_i  = TW'($urandom);
      start_i     = (exp_q[j].busy && (j < exp_q.size() - 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    start_i    = 1'b0;
    model_zone = exp_q[exp_q.size() - 1].zone;
  endtask

  initial begin
    rst_ni      = 1'b0;
    en_i        = 1'b1;
    start_i     = 1'b0;
    zone_mask_i = '0;
    duration_i  = '0;
    abort_i     = 1'b0;
    step();
    chk("reset.valve", 32'(valve_o), 32'd0);
    chk("reset.busy", 32'(busy_o), 32'd0);
    chk("reset.done", 32'(done_o), 32'd0);
    chk("reset.aborted", 32'(aborted_o), 32'd0);
    chk("reset.cur_zone", 32'(cur_zone_o), 32'd0);
    rst_ni = 1'b1;
    step();

    play(8'b0010_0101, 3, -1, 0, -1);
    play(8'h80, 0, -1, 0, -1);
    play(8'h00, 5, -1, 0, -1);

    // start with en low is ignored
    en_i        = 1'b0;
    start_i     = 1'b1;
    zone_mask_i = 8'hff;
    step();
    start_i = 1'b0;
    en_i    = 1'b1;
    chk("en_low.busy", 32'(busy_o), 32'd0);
    chk("en_low.valve", 32'(valve_o), 32'd0);
    step();
    chk("en_low.busy2", 32'(busy_o), 32'd0);

    // abort in idle still pulses
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("idle_abort.pulse", 32'(aborted_o), 32'd1);
    chk("idle_abort.done", 32'(done_o), 32'd0);
    step();
    chk("idle_abort.pulse_end", 32'(aborted_o), 32'd0);

    // abort during second zone's open window (index: 2 lead + 3 open + 5 gap + 1)
    play(8'b0000_0101, 3, -1, 0, 11);
    play(8'b0001_0010, 2, -1, 0, -1);

    // pause mid-open with two counts left
    play(8'h02, 4, 3, 5, -1);

    for (int r = 0; r < 12; r++) begin
      play(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 4)), -1, 0, -1);
    end

    // asynchronous reset mid-open
    zone_mask_i = 8'h01;
    duration_i  = 16'd6;
    start_i     = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    step();
    chk("pre_reset.valve", 32'(valve_o), 32'h01);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_reset.valve", 32'(valve_o), 32'd0);
    chk("async_reset.busy", 32'(busy_o), 32'd0);
    chk("async_reset.cur_zone", 32'(cur_zone_o), 32'd0);
    step();
    rst_ni     = 1'b1;
    model_zone = 0;
    step();
    chk("post_reset.busy", 32'(busy_o), 32'd0);
    play(8'b1000_0001, 1, -1, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/valve_zone_sequencer.md
Name: valve_zone_sequencer

Overview:
- Parametrised successor of the 3-to-8 enable decoder in the sprinkler valve path.
- Runs a watering cycle: steps through a captured zone mask in ascending zone order.
- Opens one valve at a time, as a one-hot output, for a programmed number of cycles, with a break-before-make dead time between zones.
- Sits between the bus/control register block and the valve drivers.

Parameters:
- NUM_ZONES, 8, number of valves; one-hot output width; legal range 2..32.
- ZONE_W, $clog2(NUM_ZONES), width of zone index (derived localparam, not overridable).
- TIME_W, 16, width of the per-zone open-duration counter.
- DEAD_CYCLES, 4, all-valves-closed cycles between consecutive zones; 0 allowed.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  run enable; low pauses the sequence.
- start  in  1  one-cycle request to begin a cycle; ignored while busy.
- zone_mask  in  NUM_ZONES  zones to water; sampled with start.
- duration  in  TIME_W  open cycles per zone; sampled with start.
- abort  in  1  terminate the sequence immediately.
- valve  out  NUM_ZONES  registered one-hot valve enables; all-zero when closed.
- cur_zone  out  ZONE_W  index of the zone selected last.
- busy  out  1  high in SCAN, OPEN, DEAD.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse after abort takes effect.

Behaviour:
- Reset (asynchronous, rst_n=0): valve=0, cur_zone=0, busy=0, done=0, aborted=0, state=IDLE, pending mask=0, counters=0. Release is synchronous to clk.
- States: IDLE, SCAN, OPEN, DEAD, DONE. All outputs are registered.
- IDLE, start=1 with en=1 and zone_mask!=0:
  - Capture pending=zone_mask and dur_q=max(duration,1); go to SCAN.
  - busy rises the following cycle.
- IDLE, start=1 with zone_mask==0: done pulses the next cycle; stay IDLE.
- IDLE, start=1 with en=0: ignored.
- SCAN (1 cycle): select the lowest set bit of pending, load cur_zone, clear that bit, load the counter with dur_q, go to OPEN.
- Latency: start sampled at edge T → valve one-hot high from edge T+2 for exactly dur_q enabled cycles.
- OPEN: valve=onehot(cur_zone); counter decrements each cycle en=1. At count 1:
  - go to DEAD if DEAD_CYCLES>0 and pending!=0;
  - else SCAN if pending!=0;
  - else DONE.
- DEAD: valve=0 for DEAD_CYCLES enabled cycles, then SCAN. DEAD is never entered after the last zone.
- DONE (1 cycle): done=1, busy=0 next cycle, then IDLE.
- Pause: en=0 in SCAN/OPEN/DEAD freezes state and counters and forces valve=0. Resuming reopens the same zone with its remaining count.
- abort: highest priority, any state. Next edge: valve=0, pending=0, state=IDLE, busy=0, aborted=1 for one cycle, done=0. Abort in IDLE still pulses aborted.
- abort and start in the same cycle: abort wins; start is discarded.
- start while busy: ignored; zone_mask/duration changes mid-run have no effect.
- Invariant: popcount(valve) ≤ 1 at all times.

Optional Feature:
- Macro: VALVE_SEQ_MANUAL_EN.
- Defined:
  - Adds ports manual_req (in, 1) and manual_zone (in, ZONE_W).
  - In IDLE with manual_req=1 and manual_zone<NUM_ZONES: valve=onehot(manual_zone) from the next edge while manual_req holds; busy stays 0.
  - start has priority over manual_req. abort clears valve.
  - Out-of-range manual_zone is ignored.
- Undefined: ports absent; valve driven only by the sequencer.

Decomposition:
- Package valve_seq_pkg: state enum (IDLE, SCAN, OPEN, DEAD, DONE) and the NUM_ZONES default constant.
- Sub-module valve_prio_enc: combinational lowest-set-bit priority encoder, NUM_ZONES → ZONE_W index plus valid. Used in SCAN.

Test Plan:
- Reset mid-OPEN, rst_n=0: valve=0, busy=0 immediately, without waiting for a clk edge.
- zone_mask=8'b0010_0101, duration=3, DEAD_CYCLES=4:
  - valve=01h for 3 cycles, 0 for 4, SCAN, 04h for 3, 0 for 4, SCAN, 20h for 3;
  - done pulses once; busy low afterwards.
- duration=0, zone_mask=8'h80: valve=80h for exactly 1 cycle, then done.
- zone_mask=0 with start: done pulses the next cycle; valve never nonzero; busy stays 0.
- Abort during the second zone's OPEN: valve=0 the next cycle; aborted=1 for 1 cycle; done never asserts; a following start runs normally.
- en=0 for 5 cycles mid-OPEN with 2 counts remaining: valve=0 during the pause, then the same zone reopens for 2 cycles. Check popcount(valve) ≤ 1 throughout.
